// File: rtl/cpu_bus_responder.sv
// Four-phase CPU bus slave with a programmable wait-state delay in front of a
// word-addressed storage window; accesses outside the window complete with o_err.
module cpu_bus_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_bus_clk,
    input  logic        i_bus_we,
    input  logic [31:0] i_bus_addr,
    input  logic [31:0] i_bus_data,
    output logic [31:0] o_bus_data,
    output logic        o_bus_data_ready,
    output logic        o_busy,
    output logic        o_err
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t                 state_q;
    logic [3:0]             cnt_q;
    logic                   we_q;
    logic [31:0]            addr_q;
    logic [31:0]            wdata_q;
    logic [31:0]            rdata_q;
    logic                   ready_q;
    logic                   busy_q;
    logic                   err_q;
    logic [31:0]            mem_q [DEPTH];

    logic                   hit;
    logic                   access;
    logic [ADDR_BITS-1:0]   idx;

    assign hit    = (addr_q[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
    assign idx    = addr_q[ADDR_BITS-1:0];
    assign access = (state_q == ST_WAIT) && (cnt_q == 4'd0);

    // Storage has no reset so it can map onto block RAM and survive reset.
    always_ff @(posedge i_clk) begin
        if (access && hit && we_q) begin
            mem_q[idx] <= wdata_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_bus_clk) begin
                        we_q    <= i_bus_we;
                        addr_q  <= i_bus_addr;
                        wdata_q <= i_bus_data;
                        cnt_q   <= WS;
                        busy_q  <= 1'b1;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        // A dropped strobe still completes here; ACK then exits at once.
                        if (!hit) begin
                            rdata_q <= 32'h0;
                            err_q   <= 1'b1;
                        end else begin
                            if (!we_q) begin
                                rdata_q <= mem_q[idx];
                            end
                            err_q <= 1'b0;
                        end
                        ready_q <= 1'b1;
                        state_q <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (!i_bus_clk) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_bus_data       = rdata_q;
    assign o_bus_data_ready = ready_q;
    assign o_busy           = busy_q;
    assign o_err            = err_q;

endmodule
